// File: rtl/piso_tx_scheduler_if.sv
// Requester/PISO-control bundle for the PISO transmit scheduler.
// master = byte producers side, slave = the scheduler.
interface piso_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                        enable;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        piso_enable;
    logic                        piso_load;
    logic [DATA_W-1:0]           piso_data;
    logic                        bit_valid;
    logic [ID_W-1:0]             grant_id;
    logic                        busy;
    logic                        frame_done;
    logic                        frame_abort;

    modport master (
        output enable, req_valid, req_data,
        input  req_ready, piso_enable, piso_load, piso_data, bit_valid,
               grant_id, busy, frame_done, frame_abort
    );

    modport slave (
        input  enable, req_valid, req_data,
        output req_ready, piso_enable, piso_load, piso_data, bit_valid,
               grant_id, busy, frame_done, frame_abort
    );
endinterface

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one PISO serializer among NUM_REQ byte
// requesters; all outputs are registered.
module piso_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk1,
    input  logic               reset,
    piso_tx_scheduler_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHIFT, S_DRAIN, S_GAP
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       gap_cnt;
    logic             pick_ok;
    logic [ID_W-1:0]  pick_idx;
    logic [ID_W:0]    rr_j;

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        rr_j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_j = {1'b0, ptr} + (ID_W+1)'(k);
            if (rr_j >= (ID_W+1)'(NUM_REQ))
                rr_j = rr_j - (ID_W+1)'(NUM_REQ);
            if (!pick_ok && bus.req_valid[rr_j[ID_W-1:0]]) begin
                pick_ok  = 1'b1;
                pick_idx = rr_j[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state           <= S_IDLE;
            ptr             <= '0;
            bit_cnt         <= '0;
            gap_cnt         <= '0;
            bus.req_ready   <= '0;
            bus.piso_enable <= 1'b0;
            bus.piso_load   <= 1'b0;
            bus.piso_data   <= '0;
            bus.bit_valid   <= 1'b0;
            bus.grant_id    <= '0;
            bus.busy        <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.frame_abort <= 1'b0;
        end else begin
            bus.req_ready   <= '0;
            bus.frame_done  <= 1'b0;
            bus.frame_abort <= 1'b0;
            // serial_out lags the shift register by one cycle, so does bit_valid
            bus.bit_valid   <= (state == S_SHIFT) && bus.enable;

            if (state == S_LOAD)
                ptr <= (bus.grant_id == ID_W'(NUM_REQ-1)) ? '0 : bus.grant_id + 1'b1;

            if (state != S_IDLE && !bus.enable) begin
                state           <= S_IDLE;
                bus.piso_enable <= 1'b0;
                bus.piso_load   <= 1'b0;
                bus.busy        <= 1'b0;
                bus.frame_abort <= 1'b1;
                bit_cnt         <= '0;
                gap_cnt         <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.enable && pick_ok) begin
                            state           <= S_LOAD;
                            bus.grant_id    <= pick_idx;
                            bus.piso_data   <= bus.req_data[pick_idx*DATA_W +: DATA_W];
                            bus.req_ready   <= NUM_REQ'(1) << pick_idx;
                            bus.piso_enable <= 1'b1;
                            bus.piso_load   <= 1'b1;
                            bus.busy        <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        state         <= S_SHIFT;
                        bus.piso_load <= 1'b0;
                        bit_cnt       <= '0;
                    end
                    S_SHIFT: begin
                        if (bit_cnt == CNT_W'(DATA_W-1)) begin
                            state          <= S_DRAIN;
                            bus.frame_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        bus.piso_enable <= 1'b0;
                        gap_cnt         <= '0;
                        if (GAP_CYCLES == 0) begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == 4'(GAP_CYCLES-1)) begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
